// File: rtl/counter_cin_driver.sv
// Burst generator for the cin count-enable of counter_ipcore, with a shadow model
// of the target count used to check the returned cout and tally its rising edges.
module counter_cin_driver #(
    parameter int unsigned CNT_W   = 4,
    parameter int unsigned PER_W   = 8,
    parameter int unsigned BURST_W = 8
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_start,
    input  logic [PER_W-1:0]   i_period,
    input  logic [BURST_W-1:0] i_burst,
    input  logic               i_chk_en,
    input  logic               i_cout,
    output logic               o_cin,
    output logic               o_busy,
    output logic               o_done,
    output logic [BURST_W-1:0] o_pulse_cnt,
    output logic [BURST_W-1:0] o_carry_cnt,
    output logic               o_carry_err
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_state_nx;
    logic [PER_W-1:0]   r_per;
    logic [PER_W-1:0]   r_gap;
    logic [BURST_W-1:0] r_n;
    logic [BURST_W-1:0] r_pulse_cnt;
    logic [BURST_W-1:0] r_carry_cnt;
    logic [CNT_W-1:0]   r_m;
    logic               r_cin;
    logic               r_cout_d;
    logic               r_carry_err;
    logic [PER_W-1:0]   w_per_eff;
    logic               w_accept;
    logic               w_fire;
    logic               w_exp_cout;
    logic               w_cout_rise;

    assign w_per_eff   = (i_period == '0) ? PER_W'(1) : i_period;
    assign w_accept    = (r_state == S_IDLE) && i_start;
    // Gap counter reaches 1 in the cycle before each pulse; it holds 0 only when P=1.
    assign w_fire      = (r_state == S_RUN) && (r_pulse_cnt != r_n) && (r_gap <= PER_W'(1));
    assign w_exp_cout  = (r_m == '1);
    assign w_cout_rise = i_cout && !r_cout_d;

    always_ff @(posedge i_clk) begin
        if (i_rst) r_state <= S_IDLE;
        else       r_state <= w_state_nx;
    end

    always_comb begin
        w_state_nx = r_state;
        case (r_state)
            S_IDLE: if (i_start) w_state_nx = (i_burst != '0) ? S_RUN : S_DONE;
            S_RUN:  if (r_pulse_cnt == r_n) w_state_nx = S_DONE;
            S_DONE: w_state_nx = S_IDLE;
            default: w_state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_per       <= '0;
            r_gap       <= '0;
            r_n         <= '0;
            r_pulse_cnt <= '0;
            r_cin       <= 1'b0;
        end else begin
            r_cin <= 1'b0;
            if (w_accept) begin
                r_per       <= w_per_eff;
                r_n         <= i_burst;
                r_gap       <= w_per_eff - PER_W'(1);
                r_pulse_cnt <= '0;
                // With P=1 the first pulse lands in the very next cycle.
                if ((i_burst != '0) && (w_per_eff == PER_W'(1))) begin
                    r_cin       <= 1'b1;
                    r_pulse_cnt <= BURST_W'(1);
                end
            end else if (w_fire) begin
                r_cin       <= 1'b1;
                r_pulse_cnt <= r_pulse_cnt + BURST_W'(1);
                r_gap       <= r_per;
            end else if ((r_state == S_RUN) && (r_gap != '0)) begin
                r_gap <= r_gap - PER_W'(1);
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_m         <= '0;
            r_cout_d    <= 1'b0;
            r_carry_cnt <= '0;
            r_carry_err <= 1'b0;
        end else begin
            r_m      <= r_m + CNT_W'(r_cin);
            r_cout_d <= i_cout;
            if (w_accept)
                r_carry_cnt <= '0;
            else if (w_cout_rise && (r_carry_cnt != '1))
                r_carry_cnt <= r_carry_cnt + BURST_W'(1);
            if (i_chk_en && (i_cout != w_exp_cout))
                r_carry_err <= 1'b1;
        end
    end

    assign o_cin       = r_cin;
    assign o_busy      = (r_state == S_RUN);
    assign o_done      = (r_state == S_DONE);
    assign o_pulse_cnt = r_pulse_cnt;
    assign o_carry_cnt = r_carry_cnt;
    assign o_carry_err = r_carry_err;

endmodule

// File: tb/tb_counter_cin_driver.sv
// Scoreboard bench for counter_cin_driver: expected cin/done cycles are queued at
// start time and retired by a negedge monitor; a small counter model supplies cout.
module tb_counter_cin_driver;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic [7:0] period = '0;
    logic [7:0] burst = '0;
    logic       chk_en = 1'b1;
    logic       cout;
    logic       cin, busy, done, carry_err;
    logic [7:0] pulse_cnt, carry_cnt;

    logic [3:0] q;
    logic       bug = 1'b0;
    logic       mon_en = 1'b0;
    int         cyc = 0;
    int         checks = 0;
    int         failures = 0;
    int         bs = 1, be = 0;
    int         cq[$];
    int         dq[$];
    int         pcq[$];

    counter_cin_driver #(.CNT_W(4), .PER_W(8), .BURST_W(8)) dut (
        .i_clk(clk), .i_rst(rst), .i_start(start), .i_period(period), .i_burst(burst),
        .i_chk_en(chk_en), .i_cout(cout), .o_cin(cin), .o_busy(busy), .o_done(done),
        .o_pulse_cnt(pulse_cnt), .o_carry_cnt(carry_cnt), .o_carry_err(carry_err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Target counter stand-in; bug mode suppresses cout at 15 to provoke carry_err.
    always @(posedge clk) begin
        if (rst) q <= '0;
        else     q <= q + {3'b000, cin};
    end
    assign cout = (q == 4'hF) && !bug;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            check("busy", {31'd0, busy}, {31'd0, (cyc >= bs && cyc <= be)});
            if (cin === 1'b1) begin
                if (cq.size() == 0) check("cin_unexpected", cyc, 32'hFFFF_FFFF);
                else                check("cin_cycle", cyc, cq.pop_front());
            end
            if (done === 1'b1) begin
                if (dq.size() == 0) begin
                    check("done_unexpected", cyc, 32'hFFFF_FFFF);
                end else begin
                    check("done_cycle", cyc, dq.pop_front());
                    check("done_pulse_cnt", {24'd0, pulse_cnt}, pcq.pop_front());
                    check("done_busy", {31'd0, busy}, 32'd0);
                end
            end
        end
    end

    task automatic run_burst(input int p, input int n);
        int t, pe;
        @(posedge clk); #1;
        t  = cyc;
        pe = (p == 0) ? 1 : p;
        start = 1'b1; period = p[7:0]; burst = n[7:0];
        for (int k = 1; k <= n; k++) cq.push_back(t + k * pe);
        dq.push_back(t + n * pe + 1);
        pcq.push_back(n);
        bs = t + 1; be = t + n * pe;
        @(posedge clk); #1;
        start = 1'b0; period = 8'($urandom); burst = 8'($urandom);
        for (int i = 0; i < n * pe + 20 && dq.size() != 0; i++) @(posedge clk);
        #1;
        check("done_seen", dq.size(), 0);
        check("cin_all_seen", cq.size(), 0);
    endtask

    initial begin
        int t;
        @(posedge clk); #1;
        rst = 1'b0;
        check("rst_cin", {31'd0, cin}, 0);
        check("rst_busy", {31'd0, busy}, 0);
        check("rst_done", {31'd0, done}, 0);
        check("rst_pulse_cnt", {24'd0, pulse_cnt}, 0);
        check("rst_carry_cnt", {24'd0, carry_cnt}, 0);
        check("rst_carry_err", {31'd0, carry_err}, 0);
        mon_en = 1'b1;

        run_burst(5, 20);
        check("p5b20_pulse_cnt", {24'd0, pulse_cnt}, 20);
        check("p5b20_carry_cnt", {24'd0, carry_cnt}, 1);
        check("p5b20_carry_err", {31'd0, carry_err}, 0);

        run_burst(1, 3);
        check("p1b3_pulse_cnt", {24'd0, pulse_cnt}, 3);
        check("p1b3_carry_cnt", {24'd0, carry_cnt}, 0);

        run_burst(7, 0);
        check("b0_pulse_cnt", {24'd0, pulse_cnt}, 0);

        run_burst(0, 2);
        check("p0b2_pulse_cnt", {24'd0, pulse_cnt}, 2);
        check("p0b2_carry_err", {31'd0, carry_err}, 0);

        // Mid-burst reset: start retriggered during RUN, rst after pulse 7.
        @(posedge clk); #1;
        t = cyc;
        start = 1'b1; period = 8'd5; burst = 8'd10;
        for (int k = 1; k <= 7; k++) cq.push_back(t + k * 5);
        bs = t + 1; be = t + 36;
        @(posedge clk); #1;
        start = 1'b0;
        while (cyc < t + 7) begin @(posedge clk); #1; end
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        while (cyc < t + 36) begin @(posedge clk); #1; end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("mid_rst_cin", {31'd0, cin}, 0);
        check("mid_rst_busy", {31'd0, busy}, 0);
        check("mid_rst_pulse_cnt", {24'd0, pulse_cnt}, 0);
        check("mid_rst_done", {31'd0, done}, 0);
        repeat (60) @(posedge clk);
        #1;
        check("mid_rst_cin_seen", cq.size(), 0);

        bug = 1'b1;
        run_burst(1, 16);
        check("bug_pulse_cnt", {24'd0, pulse_cnt}, 16);
        check("bug_carry_cnt", {24'd0, carry_cnt}, 0);
        check("bug_carry_err", {31'd0, carry_err}, 1);
        repeat (10) @(posedge clk);
        #1;
        check("bug_carry_err_sticky", {31'd0, carry_err}, 1);
        bug = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("bug_rst_carry_err", {31'd0, carry_err}, 0);
        repeat (3) @(posedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
